// File: rtl/trng_word_packer_if.sv
// trng_word_packer_if
//   Bundles the bit-input side and the word-output side of the TRNG word
//   packer. Signal names match the packer's original port names.
//   Parameters: WIDTH (bits per word), DROP_W (dropped-bit counter width).
//   Modports:
//     master - the surrounding logic: drives enable, bit_in, bit_valid,
//              word_ready; observes word_out, word_valid, fill_level,
//              drop_count.
//     slave  - the packer itself (opposite directions).
interface trng_word_packer_if #(
    parameter int WIDTH  = 32,
    parameter int DROP_W = 16
);
    localparam int FW = $clog2(WIDTH + 1);

    logic              enable;
    logic              bit_in;
    logic              bit_valid;
    logic [WIDTH-1:0]  word_out;
    logic              word_valid;
    logic              word_ready;
    logic [FW-1:0]     fill_level;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output enable, bit_in, bit_valid, word_ready,
        input  word_out, word_valid, fill_level, drop_count
    );

    modport slave (
        input  enable, bit_in, bit_valid, word_ready,
        output word_out, word_valid, fill_level, drop_count
    );
endinterface

// File: rtl/trng_word_packer.sv
// trng_word_packer
//   Packs single debiased bits into WIDTH-bit words and presents them on a
//   valid/ready output slot. When the slot is stalled one completed word is
//   held internally and every further offered bit is discarded and counted
//   in a saturating drop counter.
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous active-high reset
//     bus  - trng_word_packer_if.slave: enable/bit_in/bit_valid in,
//            word_out/word_valid out, word_ready in, fill_level and
//            drop_count status out. All outputs are registered or derived
//            only from registers.
module trng_word_packer #(
    parameter int WIDTH  = 32,
    parameter int DROP_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    trng_word_packer_if.slave    bus
);
    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] LAST = FW'(WIDTH - 1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              valid_q, valid_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              offer;
    logic              slot_free;
    logic [WIDTH-1:0]  shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_d    = word_q;
        valid_d   = valid_q;
        drop_d    = drop_q;
        offer     = bus.enable && bus.bit_valid;
        slot_free = !valid_q || bus.word_ready;
        // First accepted bit migrates down to bit 0 after WIDTH shifts.
        shifted   = {bus.bit_in, shreg_q[WIDTH-1:1]};

        // Consumption clears valid; a load below in the same cycle overrides.
        if (valid_q && bus.word_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            COLLECT: begin
                if (offer) begin
                    shreg_d = shifted;
                    if (cnt_q != LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (slot_free) begin
                        word_d  = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        // Completed word parks in shreg until the slot frees.
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (offer && (drop_q != '1)) begin
                    drop_d = drop_q + 1'b1;
                end
                if (slot_free) begin
                    word_d  = shreg_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.fill_level = (state_q == HOLD) ? FW'(WIDTH) : cnt_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_trng_word_packer.sv
// tb_trng_word_packer
//   Directed and random stimulus for trng_word_packer (WIDTH=8, DROP_W=4).
//   A behavioural model (bit queue, output slot, held word, saturating
//   integer counter) predicts every output each cycle.
module tb_trng_word_packer;
    localparam int W  = 8;
    localparam int DW = 4;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    trng_word_packer_if #(.WIDTH(W), .DROP_W(DW)) bus ();

    trng_word_packer #(.WIDTH(W), .DROP_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural model state
    bit          m_bits[$];
    logic [W-1:0] m_word;
    logic [W-1:0] m_held_word;
    bit          m_valid;
    bit          m_held;
    int          m_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_word      = '0;
        m_held_word = '0;
        m_valid     = 1'b0;
        m_held      = 1'b0;
        m_drop      = 0;
    endtask

    task automatic model_step(input bit en, input bit b, input bit bv, input bit rdy);
        bit          free;
        bit          offered;
        logic [W-1:0] w;
        free    = !m_valid || rdy;
        offered = en && bv;
        if (m_valid && rdy) m_valid = 1'b0;
        if (m_held) begin
            if (offered && m_drop < DROP_MAX) m_drop++;
            if (free) begin
                m_word  = m_held_word;
                m_valid = 1'b1;
                m_held  = 1'b0;
            end
        end else if (offered) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                w = '0;
                for (int i = 0; i < W; i++) w[i] = m_bits[i];
                m_bits.delete();
                if (free) begin
                    m_word  = w;
                    m_valid = 1'b1;
                end else begin
                    m_held      = 1'b1;
                    m_held_word = w;
                end
            end
        end
    endtask

    task automatic compare_all();
        int exp_fill;
        exp_fill = m_held ? W : m_bits.size();
        check("word_valid", 64'(bus.word_valid), 64'(m_valid));
        check("word_out",   64'(bus.word_out),   64'(m_word));
        check("fill_level", 64'(bus.fill_level), 64'(exp_fill));
        check("drop_count", 64'(bus.drop_count), 64'(m_drop));
    endtask

    task automatic step(input bit en, input bit b, input bit bv, input bit rdy);
        bus.enable     = en;
        bus.bit_in     = b;
        bus.bit_valid  = bv;
        bus.word_ready = rdy;
        @(posedge clk);
        model_step(en, b, bv, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.word_ready = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        logic [W-1:0] pat;

        // Reset state
        do_reset();
        check("reset_word_out", 64'(bus.word_out), 64'h0);
        check("reset_fill", 64'(bus.fill_level), 64'h0);

        // Packing order: 1,0,1,1,0,0,1,0 -> 0x4D
        pat = 8'b0100_1101;
        for (int i = 0; i < W; i++) step(1'b1, pat[i], 1'b1, 1'b1);
        check("pack_valid", 64'(bus.word_valid), 64'h1);
        check("pack_word", 64'(bus.word_out), 64'h4D);
        check("pack_fill", 64'(bus.fill_level), 64'h0);
        check("pack_drop", 64'(bus.drop_count), 64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("pack_consumed", 64'(bus.word_valid), 64'h0);
        check("pack_word_kept", 64'(bus.word_out), 64'h4D);

        // Stall and hold: 16 ones, then 3 dropped bits
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("hold_word", 64'(bus.word_out), 64'hFF);
        check("hold_fill", 64'(bus.fill_level), 64'h8);
        check("hold_drop", 64'(bus.drop_count), 64'h3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("release_valid", 64'(bus.word_valid), 64'h1);
        check("release_word", 64'(bus.word_out), 64'hFF);
        check("release_fill", 64'(bus.fill_level), 64'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("release_empty", 64'(bus.word_valid), 64'h0);

        // HOLD release with a bit offered in the same cycle: dropped
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("release_offer_drop", 64'(bus.drop_count), 64'h1);
        check("release_offer_fill", 64'(bus.fill_level), 64'h0);

        // Same-cycle consume and load
        do_reset();
        for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        pat = 8'hA5;
        for (int i = 0; i < W - 1; i++) step(1'b1, pat[i], 1'b1, 1'b0);
        step(1'b1, pat[W-1], 1'b1, 1'b1);
        check("b2b_valid", 64'(bus.word_valid), 64'h1);
        check("b2b_word", 64'(bus.word_out), 64'hA5);
        check("b2b_drop", 64'(bus.drop_count), 64'h0);

        // Enable gating: 1,1,0,1 | 10 disabled strobes | 0,1,1,1 -> 0xEB
        do_reset();
        pat = 8'hEB;
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom), 1'b1, 1'b1);
        check("gate_fill", 64'(bus.fill_level), 64'h4);
        for (int i = 4; i < W; i++) step(1'b1, pat[i], 1'b1, 1'b1);
        check("gate_word", 64'(bus.word_out), 64'hEB);
        check("gate_valid", 64'(bus.word_valid), 64'h1);
        check("gate_drop", 64'(bus.drop_count), 64'h0);

        // Saturation: reach HOLD, then 20 offers
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("sat_drop", 64'(bus.drop_count), 64'hF);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("sat_hold", 64'(bus.drop_count), 64'hF);

        // Reset mid-word, then 0,0,0,0,0,0,0,1 -> 0x80
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        do_reset();
        check("rst_mid_valid", 64'(bus.word_valid), 64'h0);
        check("rst_mid_fill", 64'(bus.fill_level), 64'h0);
        check("rst_mid_word", 64'(bus.word_out), 64'h0);
        pat = 8'h80;
        for (int i = 0; i < W; i++) step(1'b1, pat[i], 1'b1, 1'b1);
        check("rst_mid_result", 64'(bus.word_out), 64'h80);
        check("rst_mid_drop", 64'(bus.drop_count), 64'h0);

        // Ready tied high: sustained throughput, no drops
        do_reset();
        for (int i = 0; i < 200; i++) step(1'b1, 1'($urandom), 1'b1, 1'b1);
        check("tput_drop", 64'(bus.drop_count), 64'h0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
